dl_hs_tx_sequencer: RTL and testbench
=====================================

// Module: dl_hs_tx_sequencer
// PURPOSE
//  Data-lane transmit sequencer driving the lane output stage (lpp, lpn, hs, s).
//  Walks the LP-11 -> LP-01 -> LP-00 -> HS-0 -> SYNC -> payload -> TRAIL -> LP-11 burst.
//  Serialises bytes from an upstream valid/ready source, LSB first, one bit per clk.
//  Output stage registers once more, so lane pins lag these outputs by 1 clk.
// PARAMETERS
//  T_LPX        2   cycles spent in LP-01 (HS request); must be >= 1
//  T_HS_PREPARE 3   cycles spent in LP-00 (HS prepare); must be >= 1
//  T_HS_ZERO    6   cycles of HS-0 (s=1, hs=0) before the sync byte; must be >= 1
//  T_HS_TRAIL   4   cycles holding inverted last payload bit; must be >= 1
//  T_HS_EXIT    3   cycles of LP-11 after the burst before a new request is accepted; must be >= 1
//  SYNC_BYTE    8'hB8  leader sequence, sent LSB first
// PORTS
//  clk        in   1  lane bit clock
//  rst_n      in   1  asynchronous reset, active low
//  tx_data    in   8  payload byte
//  tx_valid   in   1  tx_data valid
//  tx_last    in   1  qualifies tx_data as final byte of the burst
//  tx_ready   out  1  1-clk pulse: tx_data/tx_last consumed this cycle
//  lpp        out  1  LP Dp level to output stage
//  lpn        out  1  LP Dn level to output stage
//  hs         out  1  HS serial bit to output stage
//  s          out  1  1 = HS drive selected, 0 = LP drive
//  busy       out  1  high in every state except STOP
//  underrun   out  1  1-clk pulse: tx_valid low at a byte boundary mid-burst
//  ulps_req   in   1  [DLSEQ_ULPS_EN only] request/hold ultra-low-power state
//  ulps_act   out  1  [DLSEQ_ULPS_EN only] high while in ULPS
// BEHAVIOUR
//  Reset (rst_n=0, async): state=STOP; lpp=1 lpn=1 hs=0 s=0; tx_ready=0 busy=0 underrun=0.
//   Reset mid-burst aborts immediately to LP-11; the byte in flight is dropped.
//  Outputs are registered; a duration of N means the state's outputs are held exactly N clks.
//  STOP     (LP-11, s=0): tx_valid=1 -> HS_RQST. tx_ready stays 0 here.
//  HS_RQST  (lpp=0 lpn=1)  T_LPX clks        -> HS_PREP
//  HS_PREP  (lpp=0 lpn=0)  T_HS_PREPARE clks -> HS_ZERO
//  HS_ZERO  (s=1 hs=0)     T_HS_ZERO clks    -> HS_SYNC
//  HS_SYNC  (s=1) emits SYNC_BYTE bits 0..7, 8 clks. On the 8th clk tx_ready=1,
//   tx_data/tx_last loaded into the shift register -> HS_DATA.
//  HS_DATA  (s=1) emits shift-register bits LSB first, 8 clks per byte. On the 8th bit clk:
//   - held byte had tx_last=1: no tx_ready -> HS_TRAIL
//   - tx_valid=1: tx_ready=1, load next byte; no gap between bytes
//   - tx_valid=0: underrun=1 -> HS_TRAIL (burst ends early)
//  HS_TRAIL (s=1) hs = ~(last payload bit) for T_HS_TRAIL clks -> HS_EXIT
//  HS_EXIT  (s=0, LP-11)   T_HS_EXIT clks -> STOP
//  While s=1, lpp/lpn hold 0. While s=0, hs holds 0.
//  Upstream keeps tx_data/tx_valid/tx_last stable until the tx_ready pulse.
//  One down-counter sized $clog2(max T_*)+1 bits, reloaded with T-1 on state entry;
//   transition when it reaches 0. A separate 3-bit counter tracks bit index, wrapping 7->0.
//  tx_valid deasserting during HS_RQST..HS_ZERO does not abort; SYNC end then behaves as
//   the tx_valid=0 boundary (underrun, zero-length payload, trail hs=~SYNC bit7 = 0).
// CONFIGURATION
//  Macro DLSEQ_ULPS_EN.
//  Defined: ulps_req/ulps_act ports exist. In STOP with ulps_req=1 and tx_valid=0:
//   ULPS_ENT (lpp=1 lpn=0) T_LPX clks -> ULPS (LP-00, ulps_act=1, busy=1) held while ulps_req=1.
//   ulps_req=0 -> ULPS_WAKE (lpp=1 lpn=0) 4*T_LPX clks -> STOP. tx_valid is ignored until STOP.
//   If tx_valid and ulps_req are both high in STOP, tx_valid wins.
//  Not defined: ports and states absent; STOP reacts only to tx_valid.
// STRUCTURE
//  Package dphy_lane_pkg: state enum (STOP, HS_RQST, HS_PREP, HS_ZERO, HS_SYNC, HS_DATA,
//   HS_TRAIL, HS_EXIT, ULPS_ENT, ULPS, ULPS_WAKE) and the LP line-state constants
//   LP11/LP10/LP01/LP00 as 2-bit {lpp,lpn}. This package is shared with the receive side.
//  One sub-module: dl_hs_serializer. It is an 8-bit shift register with a bit counter,
//   load/shift controls and byte_done/last_bit outputs.
// TESTING
//  Use defaults throughout. Each scenario checks every cycle against a cycle-accurate model.
//  1. Single byte 8'hA5 with tx_last=1:
//     - LP01 for 2 clks, LP00 for 3, HS0 for 6
//     - hs bits 0,0,0,1,1,1,0,1 then 1,0,1,0,0,1,0,1
//     - trail hs=0 for 4 clks, LP11 for 3 clks, then busy=0
//  2. Three bytes 01,FF,80, tx_valid held, last on 80:
//     - tx_ready pulses exactly 3 times, 8 clks apart
//     - 24 contiguous payload bits, trail hs=0
//  3. Underrun: tx_valid dropped after the first byte 8'h7F, tx_last=0:
//     - underrun pulses once at that byte's 8th bit
//     - trail hs=1, return to STOP, no further tx_ready
//  4. Reset asserted during HS_DATA:
//     - same cycle: lpp=lpn=1, s=0, hs=0, busy=0
//     - after release, the next request gives a clean full burst
//  5. Back-to-back bursts: tx_valid re-asserted during HS_EXIT:
//     - HS_RQST starts only after 3 LP-11 clks plus the STOP cycle
//  6. [DLSEQ_ULPS_EN] ulps_req for 20 clks:
//     - LP10 for 2 clks, then LP00 with ulps_act=1
//     - after release, LP10 for 8 clks, then LP11

Source files
------------

// File: rtl/dphy_lane_pkg.sv
// D-PHY data-lane definitions shared by the transmit and receive sides:
// lane sequencer states, LP line-state encodings as {lpp,lpn} and small
// decode helpers.
package dphy_lane_pkg;

    typedef enum logic [3:0] {
        STOP,
        HS_RQST,
        HS_PREP,
        HS_ZERO,
        HS_SYNC,
        HS_DATA,
        HS_TRAIL,
        HS_EXIT,
        ULPS_ENT,
        ULPS,
        ULPS_WAKE
    } lane_state_t;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP10 = 2'b10;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    // LP line level driven in each state; HS states keep both LP lines low.
    function automatic logic [1:0] lp_level(input lane_state_t st);
        case (st)
            STOP, HS_EXIT:       return LP11;
            HS_RQST:             return LP01;
            ULPS_ENT, ULPS_WAKE: return LP10;
            default:             return LP00;
        endcase
    endfunction

    // High when the HS driver owns the lane.
    function automatic logic hs_drive(input lane_state_t st);
        return (st == HS_ZERO) || (st == HS_SYNC) || (st == HS_DATA) || (st == HS_TRAIL);
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dl_hs_serializer.sv
// 8-bit LSB-first shift register with a wrapping 3-bit bit index.
// next_bit is the bit that will be on the wire after the coming edge, so the
// sequencer can register its hs output without an extra stage of latency.
module dl_hs_serializer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] din,
    output logic       next_bit,
    output logic       byte_done,
    output logic       last_bit
);

    logic [7:0] sreg;
    logic [2:0] bcnt;

    // Load a new byte (index restarts at 0) or shift one bit out per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            bcnt <= '0;
        end else if (load) begin
            sreg <= din;
            bcnt <= '0;
        end else if (shift) begin
            sreg <= {1'b0, sreg[7:1]};
            bcnt <= bcnt + 3'd1;
        end
    end

    assign byte_done = (bcnt == 3'd7);
    assign last_bit  = sreg[0];
    assign next_bit  = load ? din[0] : (shift ? sreg[1] : sreg[0]);

endmodule

// File: rtl/dl_hs_tx_sequencer.sv
// Data-lane HS transmit sequencer: LP-11 -> LP-01 -> LP-00 -> HS-0 -> SYNC ->
// payload -> TRAIL -> LP-11. Lane outputs are registered from the next state.
// tx_ready/underrun are decoded from the current state and tx_valid so that
// the strobe and the load edge fall in the same cycle.
// Optional ultra-low-power state support: define DLSEQ_ULPS_EN.
module dl_hs_tx_sequencer
    import dphy_lane_pkg::*;
#(
    parameter int unsigned T_LPX        = 2,
    parameter int unsigned T_HS_PREPARE = 3,
    parameter int unsigned T_HS_ZERO    = 6,
    parameter int unsigned T_HS_TRAIL   = 4,
    parameter int unsigned T_HS_EXIT    = 3,
    parameter logic [7:0]  SYNC_BYTE    = 8'hB8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       lpp,
    output logic       lpn,
    output logic       hs,
    output logic       s,
    output logic       busy,
    output logic       underrun
`ifdef DLSEQ_ULPS_EN
    ,
    input  logic       ulps_req,
    output logic       ulps_act
`endif
);

    localparam int unsigned T_WAKE = 4 * T_LPX;
    localparam int unsigned T_MAX  = umax(umax(umax(T_LPX, T_HS_PREPARE), umax(T_HS_ZERO, T_HS_TRAIL)),
                                          umax(T_HS_EXIT, T_WAKE));
    localparam int unsigned CW     = $clog2(T_MAX) + 1;

    lane_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last_q;
    logic          load_sync, load_data, load, shift;
    logic [7:0]    din;
    logic          next_bit, byte_done, last_bit;
    logic          hs_n;

    dl_hs_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .din       (din),
        .next_bit  (next_bit),
        .byte_done (byte_done),
        .last_bit  (last_bit)
    );

    assign load  = load_sync | load_data;
    assign shift = ((state == HS_SYNC) || (state == HS_DATA)) && !load_data;
    assign din   = load_sync ? SYNC_BYTE : tx_data;

    // Next-state, duration counter and handshake strobes.
    always_comb begin
        state_n   = state;
        cnt_n     = (cnt == '0) ? cnt : cnt - CW'(1);
        load_sync = 1'b0;
        load_data = 1'b0;
        tx_ready  = 1'b0;
        underrun  = 1'b0;
        case (state)
            STOP: begin
                if (tx_valid) begin
                    state_n = HS_RQST;
                    cnt_n   = CW'(T_LPX - 1);
                end
`ifdef DLSEQ_ULPS_EN
                else if (ulps_req) begin
                    state_n = ULPS_ENT;
                    cnt_n   = CW'(T_LPX - 1);
                end
`endif
            end
            HS_RQST: if (cnt == '0) begin
                state_n = HS_PREP;
                cnt_n   = CW'(T_HS_PREPARE - 1);
            end
            HS_PREP: if (cnt == '0) begin
                state_n = HS_ZERO;
                cnt_n   = CW'(T_HS_ZERO - 1);
            end
            HS_ZERO: if (cnt == '0) begin
                state_n   = HS_SYNC;
                load_sync = 1'b1;
            end
            HS_SYNC, HS_DATA: if (byte_done) begin
                if ((state == HS_DATA) && last_q) begin
                    state_n = HS_TRAIL;
                    cnt_n   = CW'(T_HS_TRAIL - 1);
                end else if (tx_valid) begin
                    state_n   = HS_DATA;
                    tx_ready  = 1'b1;
                    load_data = 1'b1;
                end else begin
                    state_n  = HS_TRAIL;
                    underrun = 1'b1;
                    cnt_n    = CW'(T_HS_TRAIL - 1);
                end
            end
            HS_TRAIL: if (cnt == '0) begin
                state_n = HS_EXIT;
                cnt_n   = CW'(T_HS_EXIT - 1);
            end
            HS_EXIT: if (cnt == '0) begin
                state_n = STOP;
            end
`ifdef DLSEQ_ULPS_EN
            ULPS_ENT: if (cnt == '0) begin
                state_n = ULPS;
            end
            ULPS: if (!ulps_req) begin
                state_n = ULPS_WAKE;
                cnt_n   = CW'(T_WAKE - 1);
            end
            ULPS_WAKE: if (cnt == '0) begin
                state_n = STOP;
            end
`endif
            default: state_n = STOP;
        endcase
    end

    // HS bit for the coming cycle: serial data, held inverted last bit in trail, else 0.
    always_comb begin
        hs_n = 1'b0;
        case (state_n)
            HS_SYNC, HS_DATA: hs_n = next_bit;
            HS_TRAIL:         hs_n = (state == HS_TRAIL) ? hs : ~last_bit;
            default:          hs_n = 1'b0;
        endcase
    end

    // State, counter and registered lane outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= STOP;
            cnt    <= '0;
            last_q <= 1'b0;
            lpp    <= 1'b1;
            lpn    <= 1'b1;
            hs     <= 1'b0;
            s      <= 1'b0;
            busy   <= 1'b0;
`ifdef DLSEQ_ULPS_EN
            ulps_act <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (load_data) begin
                last_q <= tx_last;
            end
            {lpp, lpn} <= lp_level(state_n);
            hs         <= hs_n;
            s          <= hs_drive(state_n);
            busy       <= (state_n != STOP);
`ifdef DLSEQ_ULPS_EN
            ulps_act <= (state_n == ULPS);
`endif
        end
    end

endmodule

// File: tb/tb_dl_hs_tx_sequencer.sv
// Self-checking bench for dl_hs_tx_sequencer. A burst-level model expands
// each burst into a per-cycle table of stimulus and expected lane outputs,
// which is then replayed against the DUT. ULPS scenario needs DLSEQ_ULPS_EN.
module tb_dl_hs_tx_sequencer;

    localparam int unsigned T_LPX        = 2;
    localparam int unsigned T_HS_PREPARE = 3;
    localparam int unsigned T_HS_ZERO    = 6;
    localparam int unsigned T_HS_TRAIL   = 4;
    localparam int unsigned T_HS_EXIT    = 3;
    localparam logic [7:0]  SYNC_BYTE    = 8'hB8;

    typedef bit [7:0] bq_t[$];
    typedef struct {
        bit       v;
        bit [7:0] d;
        bit       l;
        bit       ureq;
        bit [7:0] exp;   // {lpp,lpn,s,hs,busy,tx_ready,underrun,ulps_act}
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data;
    logic       tx_valid, tx_last;
    logic       tx_ready, lpp, lpn, hs, s, busy, underrun;
    logic       act_w;
    logic       ulps_req;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc    = 0;
    int unsigned obs_rdy = 0;
    int unsigned exp_rdy = 0;
    cyc_t        q[$];

    dl_hs_tx_sequencer #(
        .T_LPX        (T_LPX),
        .T_HS_PREPARE (T_HS_PREPARE),
        .T_HS_ZERO    (T_HS_ZERO),
        .T_HS_TRAIL   (T_HS_TRAIL),
        .T_HS_EXIT    (T_HS_EXIT),
        .SYNC_BYTE    (SYNC_BYTE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_last  (tx_last),
        .tx_ready (tx_ready),
        .lpp      (lpp),
        .lpn      (lpn),
        .hs       (hs),
        .s        (s),
        .busy     (busy),
        .underrun (underrun)
`ifdef DLSEQ_ULPS_EN
        ,
        .ulps_req (ulps_req),
        .ulps_act (act_w)
`endif
    );

`ifndef DLSEQ_ULPS_EN
    assign act_w = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic bit [7:0] ex(input bit a_lpp, input bit a_lpn, input bit a_s, input bit a_hs,
                                    input bit a_busy, input bit a_rdy, input bit a_und, input bit a_act);
        return {a_lpp, a_lpn, a_s, a_hs, a_busy, a_rdy, a_und, a_act};
    endfunction

    function automatic logic [7:0] obs();
        return {lpp, lpn, s, hs, busy, tx_ready, underrun, act_w};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push(input bit v, input bit [7:0] d, input bit l, input bit ureq, input bit [7:0] e);
        cyc_t c;
        c.v = v; c.d = d; c.l = l; c.ureq = ureq; c.exp = e;
        q.push_back(c);
        if (e[2]) exp_rdy++;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) push(1'b0, 8'($urandom), 1'b0, 1'b0, ex(1,1,0,0,0,0,0,0));
    endtask

    // What the upstream source offers: the next unconsumed byte, or (for an
    // empty burst) a short request pulse that withdraws before SYNC ends.
    function automatic void offer(input bq_t bytes, input bit with_last, input int unsigned cur,
                                  input int unsigned hold, output bit v, output bit [7:0] d, output bit l);
        v = (cur < bytes.size()) || (hold > 0);
        d = (cur < bytes.size()) ? bytes[cur] : 8'($urandom);
        l = with_last && (cur + 1 == bytes.size());
    endfunction

    // Expand one burst into per-cycle entries, starting with the STOP cycle
    // in which the request is first seen.
    task automatic burst(input bq_t bytes, input bit with_last);
        int unsigned cur;
        int unsigned hold;
        bit v, l, hsb, is_last, more;
        bit [7:0] d, word;
        cur  = 0;
        hold = (bytes.size() == 0) ? 2 : 0;
        offer(bytes, with_last, cur, hold, v, d, l);
        push(v, d, l, 1'b0, ex(1,1,0,0,0,0,0,0));
        if (hold > 0) hold--;
        repeat (T_LPX) begin
            offer(bytes, with_last, cur, hold, v, d, l);
            push(v, d, l, 1'b0, ex(0,1,0,0,1,0,0,0));
            if (hold > 0) hold--;
        end
        repeat (T_HS_PREPARE) begin
            offer(bytes, with_last, cur, hold, v, d, l);
            push(v, d, l, 1'b0, ex(0,0,0,0,1,0,0,0));
        end
        repeat (T_HS_ZERO) begin
            offer(bytes, with_last, cur, hold, v, d, l);
            push(v, d, l, 1'b0, ex(0,0,1,0,1,0,0,0));
        end
        word    = SYNC_BYTE;
        is_last = 1'b0;
        more    = 1'b1;
        hsb     = 1'b0;
        while (more) begin
            bit [7:0] this_word;
            this_word = word;
            for (int i = 0; i < 8; i++) begin
                offer(bytes, with_last, cur, 0, v, d, l);
                hsb = this_word[i];
                if (i != 7) begin
                    push(v, d, l, 1'b0, ex(0,0,1,hsb,1,0,0,0));
                end else if (is_last) begin
                    push(v, d, l, 1'b0, ex(0,0,1,hsb,1,0,0,0));
                    more = 1'b0;
                end else if (v) begin
                    push(v, d, l, 1'b0, ex(0,0,1,hsb,1,1,0,0));
                    word    = d;
                    is_last = l;
                    cur++;
                end else begin
                    push(v, d, l, 1'b0, ex(0,0,1,hsb,1,0,1,0));
                    more = 1'b0;
                end
            end
        end
        repeat (T_HS_TRAIL) push(1'b0, 8'($urandom), 1'b0, 1'b0, ex(0,0,1,~hsb,1,0,0,0));
        repeat (T_HS_EXIT)  push(1'b0, 8'($urandom), 1'b0, 1'b0, ex(1,1,0,0,1,0,0,0));
    endtask

    // Next burst's request raised already during the HS_EXIT cycles.
    task automatic preassert(input bit [7:0] b, input bit l);
        for (int i = 0; i < int'(T_HS_EXIT); i++) begin
            q[q.size() - 1 - i].v = 1'b1;
            q[q.size() - 1 - i].d = b;
            q[q.size() - 1 - i].l = l;
        end
    endtask

    task automatic play_n(input int unsigned n);
        cyc_t e;
        repeat (n) begin
            if (q.size() == 0) break;
            e = q.pop_front();
            @(negedge clk);
            tx_valid = e.v;
            tx_data  = e.d;
            tx_last  = e.l;
            ulps_req = e.ureq;
            #1;
            check($sformatf("cyc%0d", cyc), obs(), e.exp);
            if (tx_ready === 1'b1) obs_rdy++;
            cyc++;
        end
    endtask

    task automatic play();
        play_n(q.size());
    endtask

    task automatic scenario_end(input string tag);
        check(tag, obs_rdy, exp_rdy);
        obs_rdy = 0;
        exp_rdy = 0;
    endtask

    initial begin
        bq_t bytes;
        int unsigned n, start;
        bit wl;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_last  = 1'b0;
        ulps_req = 1'b0;
        @(negedge clk);
        #1;
        check("reset_state", obs(), ex(1,1,0,0,0,0,0,0));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single byte A5 with last
        idle(2);
        bytes = {8'hA5};
        burst(bytes, 1'b1);
        idle(2);
        play();
        scenario_end("s1_ready_count");

        // 2: three bytes, valid held, last on 80
        bytes = {8'h01, 8'hFF, 8'h80};
        burst(bytes, 1'b1);
        idle(2);
        play();
        scenario_end("s2_ready_count");

        // 3: underrun after 7F without last
        bytes = {8'h7F};
        burst(bytes, 1'b0);
        idle(3);
        play();
        scenario_end("s3_ready_count");

        // 4: reset during HS_DATA, then a clean burst
        bytes = {8'hA5, 8'h3C};
        burst(bytes, 1'b1);
        play_n(1 + T_LPX + T_HS_PREPARE + T_HS_ZERO + 8 + 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_burst", obs(), ex(1,1,0,0,0,0,0,0));
        q.delete();
        obs_rdy  = 0;
        exp_rdy  = 0;
        tx_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        bytes = {8'h5A, 8'hC6};
        burst(bytes, 1'b1);
        idle(2);
        play();
        scenario_end("s4_ready_count");

        // 5: back-to-back, next request raised during HS_EXIT
        bytes = {8'h3C};
        burst(bytes, 1'b1);
        preassert(8'hC3, 1'b1);
        bytes = {8'hC3};
        burst(bytes, 1'b1);
        idle(2);
        play();
        scenario_end("s5_ready_count");

        // zero-length burst (valid withdrawn before SYNC end); ulps_req
        // raised alongside the request, which must lose to tx_valid
        start = q.size();
        bytes = {};
        burst(bytes, 1'b0);
        q[start].ureq = 1'b1;
        idle(2);
        play();
        scenario_end("s_empty_ready_count");

`ifdef DLSEQ_ULPS_EN
        // 6: ulps_req held for 20 clks
        push(1'b0, 8'h00, 1'b0, 1'b1, ex(1,1,0,0,0,0,0,0));
        repeat (T_LPX) push(1'b0, 8'h00, 1'b0, 1'b1, ex(1,0,0,0,1,0,0,0));
        repeat (20 - 1 - T_LPX) push(1'b0, 8'h00, 1'b0, 1'b1, ex(0,0,0,0,1,0,0,1));
        push(1'b0, 8'h00, 1'b0, 1'b0, ex(0,0,0,0,1,0,0,1));
        repeat (4 * T_LPX) push(1'b1, 8'h11, 1'b1, 1'b0, ex(1,0,0,0,1,0,0,0));
        idle(2);
        play();
        scenario_end("s6_ready_count");
`endif

        // randomized bursts
        for (int k = 0; k < 8; k++) begin
            n  = $urandom_range(0, 3);
            wl = ($urandom_range(0, 3) != 0) && (n > 0);
            bytes = {};
            for (int j = 0; j < int'(n); j++) bytes.push_back(8'($urandom));
            burst(bytes, wl);
            idle($urandom_range(0, 3));
        end
        play();
        scenario_end("rand_ready_count");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
